lfsr_share_ctrl: RTL and testbench
==================================

# lfsr_share_ctrl

Time-multiplexes one 6-bit XNOR-feedback LFSR (taps 6,5) among N_REQ requesters, each with its own saved sequence state. Requesters ask for bursts of pseudo-random words. The block arbitrates round-robin, restores the winner's context into the shared LFSR core and streams words under ready/valid backpressure. At burst end it writes the advanced state back. It sits between the test-pattern / scrambler clients and the output mux.

## Interface
- N_REQ, 4, number of requesters (2..8)
- BURST_W, 4, width of per-requester burst length field; words per burst = value+1
- IDX_W, $clog2(N_REQ), owner index width (derived)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  per-requester burst request, sampled only in IDLE
- burst_len  in  N_REQ*BURST_W  packed lengths, requester i at [i*BURST_W +: BURST_W]
- seed_we  in  1  context write strobe
- seed_sel  in  IDX_W  context to write
- seed_data  in  6  seed value
- ready  in  1  downstream accepts data this cycle
- valid  out  1  data holds a word
- data  out  6  current LFSR word, bits [6:1] order
- owner  out  IDX_W  index of the granted requester
- grant  out  N_REQ  one-hot grant, held LOAD through SAVE
- done  out  1  one-cycle pulse in SAVE

## Operation
- Contexts: N_REQ 6-bit registers, reset to 0. Step rule: s[1] <= s[5] XNOR s[6]; s[i] <= s[i-1] for i=6..2. From 0 the sequence is 0x00, 0x01, 0x03, 0x07, 0x0F, 0x1F, 0x3E…, period 63.
- 0x3F is the lockup state. A seed write of 0x3F stores 0x00.
- FSM:
  - IDLE: if req != 0, pick the first set bit after last_owner (wrapping), go to LOAD. last_owner resets to N_REQ-1, so index 0 wins first.
  - LOAD: core <= context[owner]; count <= burst_len[owner]; grant asserted. Go to RUN.
  - RUN: valid=1, data=core. On valid&ready: core steps. If count==0, go to SAVE; else count decrements.
  - SAVE: context[owner] <= core, which is already advanced past the last word. done=1, last_owner <= owner. Go to IDLE.
- Deasserting req mid-burst has no effect; the burst completes.
- A seed write to a non-active context applies immediately in any state.
- A seed write to the active context during LOAD/RUN updates the context register, and SAVE then skips its writeback. The seed wins and the running burst is unaffected.
- A seed write coincident with SAVE on the same index: the seed wins.
- ready low holds data and valid stable; the core does not step.

## Timing
- Reset values: valid=0, data=0, owner=0, grant=0, done=0, FSM=IDLE, all contexts 0, last_owner=N_REQ-1.
- From req sampled high in IDLE (edge k): LOAD at k+1, first valid at k+2.
- With ready held high, a burst of L words occupies L cycles of valid. Total IDLE→IDLE is L+3 cycles, and the next grant's first valid arrives 2 cycles after the IDLE sample.
- data is registered (core output). Outputs have no combinational path from inputs except none; grant, owner and valid are all registered.
- Reset asserted mid-burst clears everything immediately. The partially advanced state is lost and the context returns to 0.

## Structure
- Shared package (`lfsr_share_pkg`) holds:
  - state enum {IDLE, LOAD, RUN, SAVE}
  - constant LFSR_W=6
  - LOCKUP=6'h3F
  - the step function
- Sub-module `lfsr_step_core` holds the 6-bit register with load (parallel), enable (step) and asynchronous reset. The controller instantiates one.
- Round-robin picker stays inline in the controller.

## Test plan
- After reset, req=4'b0001, burst_len[0]=3, ready=1 → grant=0001; valid for 4 cycles with data 0x00,0x01,0x03,0x07; done pulses; context0 becomes 0x0F.
- Repeat requester 0 with burst_len=1 → data 0x0F,0x1F; context0=0x3E. This proves context continuity.
- req=4'b1111 held continuously, all burst_len=0 → grants in order 0,1,2,3,0, each emitting 0x00 the first time around; owner tracks the grant index.
- ready toggled 1,0,0,1 during a burst → data holds across ready low, and no word is skipped or duplicated.
- Seed tests:
  - seed_we with sel=2 and data=0x3F → context2 reads back 0x00 as the first word of its next burst.
  - seed write to sel=owner mid-RUN with 0x05 → the burst continues unchanged, and the next burst starts at 0x05.
- Assert reset during RUN of requester 1 → all outputs 0 within the same cycle; requester 1's next burst starts at 0x00.

Source files
------------

// File: rtl/lfsr_share_pkg.sv
// Shared types, constants and LFSR helpers for the shared-LFSR controller.
package lfsr_share_pkg;

  localparam int LFSR_W = 6;
  localparam logic [LFSR_W-1:0] LOCKUP = 6'h3F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    SAVE = 2'd3
  } state_t;

  // XNOR feedback from taps 6,5; bit 0 here is sequence bit 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ~(s[LFSR_W-1] ^ s[LFSR_W-2])};
  endfunction

  // All-ones never leaves itself under XNOR feedback, so it is mapped to zero.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] v);
    return (v == LOCKUP) ? {LFSR_W{1'b0}} : v;
  endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// Shared 6-bit LFSR register: parallel load has priority over a step.
module lfsr_step_core
  import lfsr_share_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              en,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_r;

  // core state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= {LFSR_W{1'b0}};
    end else if (load) begin
      q_r <= load_val;
    end else if (en) begin
      q_r <= lfsr_step(q_r);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Round-robin time-multiplexing of one LFSR among N_REQ saved contexts,
// streaming bursts under ready/valid and writing the advanced state back.
module lfsr_share_ctrl
  import lfsr_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BURST_W = 4,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*BURST_W-1:0] burst_len,
  input  logic                     seed_we,
  input  logic [IDX_W-1:0]         seed_sel,
  input  logic [LFSR_W-1:0]        seed_data,
  input  logic                     ready,
  output logic                     valid,
  output logic [LFSR_W-1:0]        data,
  output logic [IDX_W-1:0]         owner,
  output logic [N_REQ-1:0]         grant,
  output logic                     done
);

  state_t              state_r, state_nx;
  logic [IDX_W-1:0]    owner_r, last_owner_r, pick_s;
  logic                found_s;
  logic [BURST_W-1:0]  count_r;
  logic [LFSR_W-1:0]   ctx_r [N_REQ];
  logic [LFSR_W-1:0]   core_q_s;
  logic                core_load_s, core_en_s;
  logic                skip_wb_r;
  logic                valid_r, done_r;
  logic [N_REQ-1:0]    grant_r;
  int unsigned         idx_s;

  lfsr_step_core u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (core_load_s),
    .load_val (ctx_r[owner_r]),
    .en       (core_en_s),
    .q        (core_q_s)
  );

  // round-robin pick: first set request strictly after the last owner
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IDX_W{1'b0}};
    idx_s   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_s = (int'(last_owner_r) + i) % N_REQ;
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        pick_s  = IDX_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // next-state and core control
  always_comb begin
    state_nx    = state_r;
    core_load_s = 1'b0;
    core_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) state_nx = LOAD;
        else         state_nx = IDLE;
      end
      LOAD: begin
        core_load_s = 1'b1;
        state_nx    = RUN;
      end
      RUN: begin
        if (ready) begin
          core_en_s = 1'b1;
          if (count_r == {BURST_W{1'b0}}) state_nx = SAVE;
          else                            state_nx = RUN;
        end else begin
          state_nx = RUN;
        end
      end
      SAVE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM, ownership, burst count and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      owner_r      <= {IDX_W{1'b0}};
      last_owner_r <= IDX_W'(N_REQ - 1);
      count_r      <= {BURST_W{1'b0}};
      valid_r      <= 1'b0;
      done_r       <= 1'b0;
      grant_r      <= {N_REQ{1'b0}};
    end else begin
      state_r <= state_nx;
      valid_r <= (state_nx == RUN);
      done_r  <= (state_nx == SAVE);
      if (state_r == IDLE && found_s) begin
        owner_r <= pick_s;
        grant_r <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
      end else if (state_nx == IDLE) begin
        grant_r <= {N_REQ{1'b0}};
      end
      if (state_r == LOAD) begin
        count_r <= burst_len[int'(owner_r)*BURST_W +: BURST_W];
      end else if (state_r == RUN && ready && count_r != {BURST_W{1'b0}}) begin
        count_r <= count_r - BURST_W'(1);
      end
      if (state_r == SAVE) begin
        last_owner_r <= owner_r;
      end
    end
  end

  // a seed landing on the active context during the burst cancels the writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skip_wb_r <= 1'b0;
    end else if (state_r == IDLE || state_r == SAVE) begin
      skip_wb_r <= 1'b0;
    end else if (seed_we && seed_sel == owner_r) begin
      skip_wb_r <= 1'b1;
    end else begin
      skip_wb_r <= skip_wb_r;
    end
  end

  // context registers: seed writes beat the SAVE writeback
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) ctx_r[i] <= {LFSR_W{1'b0}};
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (seed_we && seed_sel == IDX_W'(i)) begin
          ctx_r[i] <= seed_fix(seed_data);
        end else if (state_r == SAVE && owner_r == IDX_W'(i) && !skip_wb_r) begin
          ctx_r[i] <= core_q_s;
        end else begin
          ctx_r[i] <= ctx_r[i];
        end
      end
    end
  end

  assign valid = valid_r;
  assign data  = core_q_s;
  assign owner = owner_r;
  assign grant = grant_r;
  assign done  = done_r;

endmodule

// File: tb/tb_lfsr_share_ctrl.sv
// Burst-level bench: a reference model of contexts and round-robin order
// predicts every word, grant and done pulse.
module tb_lfsr_share_ctrl;

  localparam int N = 4;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic [N*BW-1:0] burst_len;
  logic          seed_we;
  logic [1:0]    seed_sel;
  logic [5:0]    seed_data;
  logic          ready;
  logic          valid;
  logic [5:0]    data;
  logic [1:0]    owner;
  logic [N-1:0]  grant;
  logic          done;

  int checks = 0;
  int errors = 0;
  int ctx_m [N];
  int lens_m [N];
  int last_m;

  lfsr_share_ctrl #(.N_REQ(N), .BURST_W(BW)) dut (
    .clk(clk), .reset(reset), .req(req), .burst_len(burst_len),
    .seed_we(seed_we), .seed_sel(seed_sel), .seed_data(seed_data),
    .ready(ready), .valid(valid), .data(data), .owner(owner),
    .grant(grant), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int step6(input int s);
    return ((s << 1) & 63) | (((s >> 5) ^ (s >> 4) ^ 1) & 1);
  endfunction

  function automatic int fix6(input int v);
    return (v == 63) ? 0 : v;
  endfunction

  function automatic int rr(input logic [N-1:0] rq);
    for (int i = 1; i <= N; i++) begin
      if (rq[(last_m + i) % N]) return (last_m + i) % N;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) ctx_m[i] = 0;
    last_m = N - 1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; seed_we = 1'b0; ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic seed_idle(input int sel, input int val);
    seed_we = 1'b1; seed_sel = 2'(sel); seed_data = 6'(val);
    @(negedge clk);
    seed_we = 1'b0;
    ctx_m[sel] = fix6(val);
  endtask

  // One burst from an IDLE negedge back to an IDLE negedge.
  // sw: word index during RUN at which to seed (99 = in SAVE, -1 = none).
  task automatic burst(input logic [N-1:0] rq, input bit hold, input int rmode,
                       input int sw, input int ssel, input int sval, input int abort_at);
    int own, len, cur, words, cyc;
    bit skip, seeded, rd;
    own = rr(rq); len = lens_m[own]; cur = ctx_m[own];
    skip = 1'b0; seeded = 1'b0;
    for (int i = 0; i < N; i++) burst_len[i*BW +: BW] = 4'(lens_m[i]);
    check("idle_valid", 32'(valid), 32'd0);
    check("idle_grant", 32'(grant), 32'd0);
    req = rq;
    @(negedge clk);
    check("load_grant", 32'(grant), 32'(1 << own));
    check("load_owner", 32'(owner), 32'(own));
    check("load_valid", 32'(valid), 32'd0);
    if (!hold) req = '0;
    words = 0; cyc = 0;
    while (words <= len && cyc < 300) begin
      @(negedge clk);
      cyc++;
      seed_we = 1'b0;
      if (abort_at >= 0 && words == abort_at) begin
        reset = 1'b1;
        #1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_data",  32'(data),  32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done",  32'(done),  32'd0);
        req = '0; ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        return;
      end
      check("run_valid", 32'(valid), 32'd1);
      check("run_data",  32'(data),  32'(cur));
      check("run_grant", 32'(grant), 32'(1 << own));
      check("run_done",  32'(done),  32'd0);
      if (sw == words && !seeded) begin
        seeded = 1'b1;
        seed_we = 1'b1; seed_sel = 2'(ssel); seed_data = 6'(sval);
        ctx_m[ssel] = fix6(sval);
        if (ssel == own) skip = 1'b1;
      end
      case (rmode)
        1: rd = ($urandom_range(0, 2) != 0);
        2: rd = (((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3);
        default: rd = 1'b1;
      endcase
      ready = rd;
      if (rd) begin
        cur = step6(cur);
        words++;
      end
    end
    if (cyc >= 300) check("burst_timeout", 32'd0, 32'd1);
    @(negedge clk);
    seed_we = 1'b0; ready = 1'b1;
    check("save_done",  32'(done),  32'd1);
    check("save_valid", 32'(valid), 32'd0);
    check("save_grant", 32'(grant), 32'(1 << own));
    if (!skip) ctx_m[own] = cur;
    if (sw == 99) begin
      seed_we = 1'b1; seed_sel = 2'(ssel); seed_data = 6'(sval);
      ctx_m[ssel] = fix6(sval);
    end
    last_m = own;
    @(negedge clk);
    seed_we = 1'b0;
    check("idle_done", 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req = '0; burst_len = '0; seed_we = 1'b0;
    seed_sel = '0; seed_data = '0; ready = 1'b1;
    for (int i = 0; i < N; i++) lens_m[i] = 0;
    model_reset();
    @(negedge clk);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data",  32'(data),  32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_done",  32'(done),  32'd0);
    reset = 1'b0;
    @(negedge clk);

    // first burst and context continuity on requester 0
    lens_m[0] = 3;
    burst(4'b0001, 1'b0, 0, -1, 0, 0, -1);
    lens_m[0] = 1;
    burst(4'b0001, 1'b0, 0, -1, 0, 0, -1);

    // continuous request round-robin from a fresh reset
    do_reset();
    for (int i = 0; i < N; i++) lens_m[i] = 0;
    for (int k = 0; k < 5; k++) burst(4'b1111, (k < 4), 0, -1, 0, 0, -1);

    // backpressure pattern 1,0,0,1
    lens_m[2] = 5;
    burst(4'b0100, 1'b0, 2, -1, 0, 0, -1);

    // lockup seed maps to zero
    seed_idle(2, 63);
    burst(4'b0100, 1'b0, 0, -1, 0, 0, -1);

    // seed the active context mid-run
    lens_m[3] = 4;
    burst(4'b1000, 1'b0, 0, 2, 3, 5, -1);
    burst(4'b1000, 1'b0, 0, -1, 0, 0, -1);

    // seed coincident with SAVE on the same index, and a non-active seed mid-run
    lens_m[1] = 2;
    burst(4'b0010, 1'b0, 0, 99, 1, 42, -1);
    burst(4'b0010, 1'b0, 0, 1, 0, 17, -1);
    burst(4'b0010, 1'b0, 0, -1, 0, 0, -1);

    // reset during requester 1's run
    lens_m[1] = 6;
    burst(4'b0010, 1'b0, 0, -1, 0, 0, 3);
    burst(4'b0010, 1'b0, 0, -1, 0, 0, -1);

    // randomized bursts
    for (int k = 0; k < 40; k++) begin
      int sw, sv;
      logic [N-1:0] rq;
      rq = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) lens_m[i] = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0: sw = -1;
        1: sw = 99;
        default: sw = $urandom_range(0, 3);
      endcase
      sv = ($urandom_range(0, 4) == 0) ? 63 : $urandom_range(0, 63);
      if ($urandom_range(0, 5) == 0) seed_idle($urandom_range(0, N - 1), $urandom_range(0, 63));
      burst(rq, 1'b0, $urandom_range(0, 2), sw, $urandom_range(0, N - 1), sv, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
